// File: rtl/uart_rx_dzj.sv
// 8N1 UART receiver with 2-FF input sync, mid-bit sampling and a one-deep valid/ack holding register.
// Good byte lands ~9.5 bit-times + 3 clks after the line falls; a byte arriving while the register is full is dropped.
module uart_rx_dzj #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX232,
  input  logic       rx_ack,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BPS_CNT / 2;
  localparam int CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta_q, rx_s_q, rx_dly_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          byte_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ferr_d    = 1'b0;
    byte_ok   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_dly_q && !rx_s_q) begin
          state_d   = S_START;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
        end
      end
      // Checking one clock past half-bit centres the data samples once sync delay is counted.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A coinciding ack frees the slot for the new byte; overrun is left as is.
    if (byte_ok) begin
      if (!valid_q || rx_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_dly_q  <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX232;
      rx_s_q    <= rx_meta_q;
      rx_dly_q  <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_rx   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_dzj.sv
// Directed bench for uart_rx_dzj at 10 clk/bit: good frames, glitch, framing error, overrun, ack race, mid-frame reset.
module tb_uart_rx_dzj;

  localparam int BPS = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line;
  logic       rx_ack;
  logic [7:0] data_rx;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_dzj #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX232     (rx_line),
    .rx_ack    (rx_ack),
    .data_rx   (data_rx),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   ferr_cnt = 0;
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   t0 = 0;
  int   lat = 0;
  logic vld_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (rx_valid === 1'b1 && vld_prev !== 1'b1) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    vld_prev = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives len clocks of a 10-bit frame; rx_ack is high only on iteration ack_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int len, input int ack_at);
    logic [9:0] fr;
    fr = {stop_b, b, 1'b0};
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc;
      rx_line = fr[i / BPS];
      rx_ack  = (i == ack_at);
    end
    rx_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
  endtask

  initial begin
    int r, f, bc;
    rst = 1'b1; rx_line = 1'b1; rx_ack = 1'b0;
    idle(3);
    chk("rst_data",  {24'd0, data_rx},   32'h00);
    chk("rst_valid", {31'd0, rx_valid},  32'd0);
    chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
    chk("rst_ovr",   {31'd0, overrun},   32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    @(negedge clk) rst = 1'b0;
    idle(3);

    // 1: single good byte, then ack
    r = rise_cnt; f = ferr_cnt;
    send_frame(8'hA5, 1'b1, 100, -1);
    idle(3);
    lat = rise_cyc - t0;
    chk("t1_lat",   {31'd0, (lat >= 97 && lat <= 100)}, 32'd1);
    chk("t1_data",  {24'd0, data_rx},  32'hA5);
    chk("t1_valid", {31'd0, rx_valid}, 32'd1);
    chk("t1_rises", rise_cnt - r,      32'd1);
    chk("t1_ferr",  ferr_cnt - f,      32'd0);
    chk("t1_busy",  {31'd0, busy},     32'd0);
    ack_pulse();
    chk("t1_ack",   {31'd0, rx_valid}, 32'd0);

    // 2: 3-clock low glitch
    r = rise_cnt; f = ferr_cnt; bc = busy_cnt;
    @(negedge clk) rx_line = 1'b0;
    idle(3);
    rx_line = 1'b1;
    idle(20);
    chk("t2_busy_len", {31'd0, (busy_cnt - bc >= 6 && busy_cnt - bc <= 8)}, 32'd1);
    chk("t2_rises",    rise_cnt - r,  32'd0);
    chk("t2_ferr",     ferr_cnt - f,  32'd0);
    chk("t2_busy",     {31'd0, busy}, 32'd0);

    // 3: stop bit low, line held low afterwards
    r = rise_cnt; f = ferr_cnt;
    send_frame(8'h3C, 1'b0, 100, -1);
    idle(20);
    chk("t3_break_busy", {31'd0, busy},     32'd1);
    chk("t3_ferr_once",  ferr_cnt - f,      32'd1);
    rx_line = 1'b1;
    idle(6);
    chk("t3_idle_busy",  {31'd0, busy},     32'd0);
    chk("t3_rises",      rise_cnt - r,      32'd0);
    chk("t3_valid",      {31'd0, rx_valid}, 32'd0);

    // 4: back-to-back, no ack -> overrun
    r = rise_cnt;
    send_frame(8'h11, 1'b1, 100, -1);
    send_frame(8'h22, 1'b1, 100, -1);
    idle(3);
    chk("t4_data",  {24'd0, data_rx},  32'h11);
    chk("t4_valid", {31'd0, rx_valid}, 32'd1);
    chk("t4_ovr",   {31'd0, overrun},  32'd1);
    chk("t4_rises", rise_cnt - r,      32'd1);
    ack_pulse();
    chk("t4_ack_valid", {31'd0, rx_valid}, 32'd0);
    chk("t4_ack_ovr",   {31'd0, overrun},  32'd0);

    // 5: ack on the exact load clock of the second byte
    send_frame(8'h55, 1'b1, 100, -1);
    send_frame(8'h66, 1'b1, 100, lat - 1);
    idle(3);
    chk("t5_data",  {24'd0, data_rx},  32'h66);
    chk("t5_valid", {31'd0, rx_valid}, 32'd1);
    chk("t5_ovr",   {31'd0, overrun},  32'd0);
    ack_pulse();
    chk("t5_ack",   {31'd0, rx_valid}, 32'd0);

    // 6: reset during bit 4 of 0xF0, then 0x0F
    f = ferr_cnt;
    send_frame(8'hF0, 1'b1, 55, -1);
    chk("t6_mid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk) rst = 1'b1;
    idle(2);
    rst = 1'b0; rx_line = 1'b1;
    chk("t6_rst_busy",  {31'd0, busy},     32'd0);
    chk("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    idle(5);
    send_frame(8'h0F, 1'b1, 100, -1);
    idle(3);
    chk("t6_data",  {24'd0, data_rx},  32'h0F);
    chk("t6_valid", {31'd0, rx_valid}, 32'd1);
    chk("t6_ovr",   {31'd0, overrun},  32'd0);
    chk("t6_ferr",  ferr_cnt - f,      32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
